// File: rtl/full_adder_core_if.sv
// Operand/result bundle for full_adder_core: inputs and enable from the master,
// combinational and registered results back from the adder.
interface full_adder_core_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             en;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;
    logic [WIDTH-1:0] S_q;
    logic             Cout_q;
    logic             V_q;

    modport master (
        output A, B, Cin, en,
        input  S, Cout, V, S_q, Cout_q, V_q
    );

    modport slave (
        input  A, B, Cin, en,
        output S, Cout, V, S_q, Cout_q, V_q
    );
endinterface

// File: rtl/full_adder_core.sv
// Ripple-carry adder cell: combinational sum/carry/overflow plus an
// enable-gated registered copy cleared by an asynchronous active-low reset.
module full_adder_core #(
    parameter int unsigned WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    full_adder_core_if.slave  bus
);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             v_d;
    logic             carry;
    logic             carry_msb_in;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             v_q;

    assign p = bus.A ^ bus.B;
    assign g = bus.A & bus.B;

    // Carry ripples LSB to MSB; carry_msb_in keeps c_{WIDTH-1} for overflow.
    always_comb begin
        s_d          = '0;
        carry        = bus.Cin;
        carry_msb_in = bus.Cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s_d[i]       = p[i] ^ carry;
            carry_msb_in = carry;
            carry        = g[i] | (carry & p[i]);
        end
        cout_d = carry;
        v_d    = carry ^ carry_msb_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
        end else if (bus.en) begin
            s_q    <= s_d;
            cout_q <= cout_d;
            v_q    <= v_d;
        end
    end

    assign bus.S      = s_d;
    assign bus.Cout   = cout_d;
    assign bus.V      = v_d;
    assign bus.S_q    = s_q;
    assign bus.Cout_q = cout_q;
    assign bus.V_q    = v_q;
endmodule

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH 1, 8 and 16.
module tb_full_adder_core;
    logic clk      = 1'b0;
    logic clk_idle = 1'b0;
    logic rst1_n;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_on   = 1'b0;

    always #5 clk = ~clk;

    full_adder_core_if #(.WIDTH(1))  bus1 ();
    full_adder_core_if #(.WIDTH(8))  bus8 ();
    full_adder_core_if #(.WIDTH(16)) bus16 ();

    full_adder_core #(.WIDTH(1))  dut1  (.clk(clk_idle), .rst_n(rst1_n), .bus(bus1));
    full_adder_core #(.WIDTH(8))  dut8  (.clk(clk),      .rst_n(rst_n),  .bus(bus8));
    full_adder_core #(.WIDTH(16)) dut16 (.clk(clk),      .rst_n(rst_n),  .bus(bus16));

    typedef struct packed {
        logic        v;
        logic        c;
        logic [63:0] s;
    } res_t;

    // Arithmetic reference: unsigned sum for S/Cout, signed range test for V.
    function automatic res_t model(int w, longint unsigned a, longint unsigned b, bit cin);
        res_t            r;
        longint unsigned sum;
        longint          lim;
        longint          sa;
        longint          sb;
        longint          tot;
        lim = longint'(1) <<< (w - 1);
        sum = a + b + longint'(cin);
        r.s = sum & ((64'd1 << w) - 64'd1);
        r.c = sum[w];
        sa  = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sb  = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
        tot = sa + sb + longint'(cin);
        r.v = (tot >= lim) || (tot < -lim);
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    res_t exp8_q;
    res_t exp16_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8_q  <= '0;
            exp16_q <= '0;
        end else begin
            if (bus8.en)  exp8_q  <= model(8,  bus8.A,  bus8.B,  bus8.Cin);
            if (bus16.en) exp16_q <= model(16, bus16.A, bus16.B, bus16.Cin);
        end
    end

    always @(negedge clk) begin : cmp
        res_t r;
        if (chk_on) begin
            r = model(1, bus1.A, bus1.B, bus1.Cin);
            check("w1_S", bus1.S, r.s);
            check("w1_Cout", bus1.Cout, r.c);
            check("w1_V", bus1.V, r.v);
            check("w1_S_q_idle", {bus1.S_q, bus1.Cout_q, bus1.V_q}, 0);
            r = model(8, bus8.A, bus8.B, bus8.Cin);
            check("w8_S", bus8.S, r.s);
            check("w8_Cout", bus8.Cout, r.c);
            check("w8_V", bus8.V, r.v);
            check("w8_S_q", bus8.S_q, exp8_q.s);
            check("w8_Cout_q", bus8.Cout_q, exp8_q.c);
            check("w8_V_q", bus8.V_q, exp8_q.v);
            r = model(16, bus16.A, bus16.B, bus16.Cin);
            check("w16_S", bus16.S, r.s);
            check("w16_Cout", bus16.Cout, r.c);
            check("w16_V", bus16.V, r.v);
            check("w16_S_q", bus16.S_q, exp16_q.s);
            check("w16_Cout_q", bus16.Cout_q, exp16_q.c);
            check("w16_V_q", bus16.V_q, exp16_q.v);
        end
    end

    logic [1:0]  sweep_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [16:0] sum16;
    logic        vref;

    initial begin
        bus1.A = '0;  bus1.B = '0;  bus1.Cin = 1'b0;  bus1.en = 1'b1;
        bus8.A = '0;  bus8.B = '0;  bus8.Cin = 1'b0;  bus8.en = 1'b0;
        bus16.A = '0; bus16.B = '0; bus16.Cin = 1'b0; bus16.en = 1'b0;
        rst1_n = 1'b1;
        rst_n  = 1'b1;
        #1;
        rst1_n = 1'b0;
        rst_n  = 1'b0;
        #10;
        check("reset_S_q8", {bus8.S_q, bus8.Cout_q, bus8.V_q}, 0);
        check("reset_S_q1", {bus1.S_q, bus1.Cout_q, bus1.V_q}, 0);
        rst1_n = 1'b1;
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // WIDTH=1 exhaustive sweep, clk idle on the 1-bit instance
        @(posedge clk); #2;
        for (int k = 0; k < 8; k++) begin
            {bus1.A, bus1.B, bus1.Cin} = k[2:0];
            #1;
            check("sweep_CoutS", {bus1.Cout, bus1.S}, sweep_tab[k]);
            #99;
        end

        rst1_n = 1'b0;
        {bus1.A, bus1.B, bus1.Cin} = 3'b111;
        #1;
        check("rst_comb_S", bus1.S, 1);
        check("rst_comb_Cout", bus1.Cout, 1);
        check("rst_comb_S_q", bus1.S_q, 0);
        #20;
        rst1_n = 1'b1;

        // WIDTH=8 wrap and overflow
        @(posedge clk); #2;
        bus8.en = 1'b1;
        bus8.A = 8'hFF; bus8.B = 8'h01; bus8.Cin = 1'b0;
        #1;
        check("ff01_S", bus8.S, 8'h00);
        check("ff01_Cout", bus8.Cout, 1);
        check("ff01_V", bus8.V, 0);
        @(posedge clk); #1;
        check("ff01_S_q", {bus8.Cout_q, bus8.V_q, bus8.S_q}, 10'b10_0000_0000);
        #1;
        bus8.A = 8'h7F; bus8.B = 8'h01; bus8.Cin = 1'b0;
        #1;
        check("7f01_S", bus8.S, 8'h80);
        check("7f01_Cout", bus8.Cout, 0);
        check("7f01_V", bus8.V, 1);
        @(posedge clk); #1;
        check("7f01_S_q", {bus8.Cout_q, bus8.V_q, bus8.S_q}, 10'b01_1000_0000);

        #1;
        bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.Cin = 1'b1;
        #1;
        check("allones_S", bus8.S, 8'hFF);
        check("allones_Cout", bus8.Cout, 1);
        bus8.B = 8'h00;
        #1;
        check("ffp1_S", bus8.S, 8'h00);
        check("ffp1_Cout", bus8.Cout, 1);

        // Load, then hold with en low
        @(posedge clk); #2;
        bus8.A = 8'h12; bus8.B = 8'h34; bus8.Cin = 1'b1;
        @(posedge clk); #1;
        check("load_S_q", bus8.S_q, 8'h47);
        check("load_Cout_q", bus8.Cout_q, 0);
        check("load_V_q", bus8.V_q, 0);
        #1;
        bus8.en = 1'b0;
        bus8.A = 8'hAA; bus8.B = 8'hBB; bus8.Cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_S_q", bus8.S_q, 8'h47);
        end

        // Async reset between edges
        #2;
        rst_n = 1'b0;
        bus8.en = 1'b1;
        #1;
        check("async_S_q", bus8.S_q, 0);
        check("async_Cout_q", bus8.Cout_q, 0);
        check("async_V_q", bus8.V_q, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("inrst_S_q", bus8.S_q, 0);
        end
        #1;
        rst_n = 1'b1;
        #1;
        check("released_S_q", bus8.S_q, 0);
        @(posedge clk); #1;
        check("post_rst_S_q", bus8.S_q, 8'h65);
        check("post_rst_Cout_q", bus8.Cout_q, 1);
        check("post_rst_V_q", bus8.V_q, 1);

        // WIDTH=16 random vectors
        bus8.en  = 1'b0;
        bus16.en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #2;
            bus16.A   = 16'($urandom);
            bus16.B   = 16'($urandom);
            bus16.Cin = 1'($urandom_range(0, 1));
            #1;
            sum16 = {1'b0, bus16.A} + {1'b0, bus16.B} + {16'd0, bus16.Cin};
            vref  = (bus16.A[15] == bus16.B[15]) && (sum16[15] != bus16.A[15]);
            check("rand_CoutS", {bus16.Cout, bus16.S}, sum16);
            check("rand_V", bus16.V, vref);
        end

        @(posedge clk); #2;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
